// File: rtl/sift_desc_pkg.sv
// Shared types, default parameters and helpers for the SIFT descriptor histogram engine.
package sift_desc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam int WIN_DEF   = 16;
    localparam int NSUB_DEF  = 4;
    localparam int NBIN_DEF  = 8;
    localparam int MAG_W_DEF = 8;
    localparam int WGT_W_DEF = 8;
    localparam int ACC_W_DEF = 18;
    localparam int OUT_W_DEF = 8;
    localparam int SHIFT_DEF = 2;

    // Operates on 32-bit containers so one function serves any ACC_W up to 31.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/desc_sub_index.sv
// Maps a row-major window sample index to its sub-region index.
module desc_sub_index
    import sift_desc_pkg::*;
#(
    parameter int WIN   = WIN_DEF,
    parameter int NSUB  = NSUB_DEF,
    parameter int N_W   = $clog2(WIN * WIN),
    parameter int SUB_W = $clog2(NSUB * NSUB)
) (
    input  logic [N_W-1:0]   n_i,
    output logic [SUB_W-1:0] sub_o
);

    localparam int  SW   = WIN / NSUB;
    localparam bit  POW2 = ((WIN & (WIN - 1)) == 0) && ((SW & (SW - 1)) == 0);

    generate
        if (POW2) begin : g_shift
            localparam int LOG_WIN = $clog2(WIN);
            localparam int LOG_SW  = $clog2(SW);
            logic [N_W-1:0] row;
            logic [N_W-1:0] col;
            logic [N_W-1:0] sub_full;
            assign row      = n_i >> LOG_WIN;
            assign col      = n_i & N_W'(WIN - 1);
            assign sub_full = (row >> LOG_SW) * N_W'(NSUB) + (col >> LOG_SW);
            assign sub_o    = SUB_W'(sub_full);
        end else begin : g_div
            logic [31:0] row;
            logic [31:0] col;
            logic [31:0] sub_full;
            logic        unused_sub_hi;
            always_comb begin
                row      = 32'(n_i) / 32'(WIN);
                col      = 32'(n_i) % 32'(WIN);
                sub_full = (row / 32'(SW)) * 32'(NSUB) + col / 32'(SW);
            end
            assign sub_o         = sub_full[SUB_W-1:0];
            assign unused_sub_hi = ^sub_full[31:SUB_W];
        end
    endgenerate

endmodule

// File: rtl/desc_hist_accum.sv
// SIFT descriptor histogram engine: accumulates weighted gradient magnitudes into
// NSUB x NSUB x NBIN bins, then streams the scaled, saturated descriptor out.
module desc_hist_accum
    import sift_desc_pkg::*;
#(
    parameter  int WIN   = WIN_DEF,
    parameter  int NSUB  = NSUB_DEF,
    parameter  int NBIN  = NBIN_DEF,
    parameter  int MAG_W = MAG_W_DEF,
    parameter  int WGT_W = WGT_W_DEF,
    parameter  int ACC_W = ACC_W_DEF,
    parameter  int OUT_W = OUT_W_DEF,
    parameter  int SHIFT = SHIFT_DEF,
    localparam int BIN_W = $clog2(NBIN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    input  logic [MAG_W-1:0] in_mag_i,
    input  logic [WGT_W-1:0] in_wgt_i,
    input  logic [BIN_W-1:0] in_bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] peak_o
);

    localparam int NSAMP  = WIN * WIN;
    localparam int NOUT   = NSUB * NSUB * NBIN;
    localparam int N_W    = $clog2(NSAMP);
    localparam int SUB_W  = $clog2(NSUB * NSUB);
    localparam int K_W    = $clog2(NOUT);
    localparam int PROD_W = MAG_W + WGT_W;

    localparam logic [31:0]      ACC_MAX32 = 32'((64'd1 << ACC_W) - 64'd1);
    localparam logic [OUT_W-1:0] OUT_MAX   = '1;

    state_e           state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             done_q, done_d;
    logic             accept;
    logic             clear;

    logic              s1_valid_q;
    logic [PROD_W-1:0] s1_prod_q;
    logic [SUB_W-1:0]  s1_sub_q;
    logic [BIN_W-1:0]  s1_bin_q;
    logic [ACC_W-1:0]  acc_q [NOUT];
    logic [ACC_W-1:0]  peak_q;

    logic [SUB_W-1:0]  cur_sub;
    logic [K_W-1:0]    wr_idx;
    logic [31:0]       acc_sum;
    logic [ACC_W-1:0]  acc_new;
    logic [ACC_W-1:0]  shifted;
    logic              unused_sum_hi;

    desc_sub_index #(
        .WIN   (WIN),
        .NSUB  (NSUB),
        .N_W   (N_W),
        .SUB_W (SUB_W)
    ) u_sub_index (
        .n_i   (n_q),
        .sub_o (cur_sub)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    clear   = 1'b1;
                    n_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid_i) begin
                    accept = 1'b1;
                    n_d    = n_q + 1'b1;
                    if (n_q == N_W'(NSAMP - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                k_d     = '0;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready_i) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_W'(NOUT - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    // Stage 2 reads and writes the same bin in one cycle, so no forwarding is needed.
    assign wr_idx        = K_W'(s1_sub_q) * K_W'(NBIN) + K_W'(s1_bin_q);
    assign acc_sum       = sat_add(32'(acc_q[wr_idx]), 32'(s1_prod_q), ACC_MAX32);
    assign acc_new       = acc_sum[ACC_W-1:0];
    assign unused_sum_hi = ^acc_sum[31:ACC_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_sub_q   <= '0;
            s1_bin_q   <= '0;
            peak_q     <= '0;
            for (int i = 0; i < NOUT; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_prod_q <= PROD_W'(in_mag_i) * PROD_W'(in_wgt_i);
                s1_sub_q  <= cur_sub;
                s1_bin_q  <= in_bin_i;
            end
            if (clear) begin
                peak_q <= '0;
                for (int i = 0; i < NOUT; i++) begin
                    acc_q[i] <= '0;
                end
            end else if (s1_valid_q) begin
                acc_q[wr_idx] <= acc_new;
                if (acc_new > peak_q) begin
                    peak_q <= acc_new;
                end
            end
        end
    end

    assign out_valid_o = (state_q == OUT);
    assign out_last_o  = out_valid_o && (k_q == K_W'(NOUT - 1));
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign peak_o      = peak_q;
    assign shifted     = acc_q[k_q] >> SHIFT;

    always_comb begin
        out_data_o = '0;
        if (out_valid_o) begin
            out_data_o = (shifted > ACC_W'(OUT_MAX)) ? OUT_MAX : shifted[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_desc_hist_accum.sv
// Directed, table-driven bench for desc_hist_accum (default and 2x2x4 configurations).
module tb_desc_hist_accum;

    localparam int NS = 256;
    localparam int NO = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_mag = '0;
    logic [7:0]  in_wgt = '0;
    logic [2:0]  in_bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [17:0] peak;

    logic        s_start = 1'b0;
    logic        s_in_valid = 1'b0;
    logic [7:0]  s_in_mag = '0;
    logic [7:0]  s_in_wgt = '0;
    logic [1:0]  s_in_bin = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [7:0]  s_out_data;
    logic        s_out_last;
    logic        s_busy;
    logic        s_done;
    logic [17:0] s_peak;

    always #5 clk = ~clk;

    desc_hist_accum dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_mag_i    (in_mag),
        .in_wgt_i    (in_wgt),
        .in_bin_i    (in_bin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done),
        .peak_o      (peak)
    );

    desc_hist_accum #(.WIN(8), .NSUB(2), .NBIN(4)) dut_s (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (s_start),
        .in_valid_i  (s_in_valid),
        .in_mag_i    (s_in_mag),
        .in_wgt_i    (s_in_wgt),
        .in_bin_i    (s_in_bin),
        .out_valid_o (s_out_valid),
        .out_ready_i (s_out_ready),
        .out_data_o  (s_out_data),
        .out_last_o  (s_out_last),
        .busy_o      (s_busy),
        .done_o      (s_done),
        .peak_o      (s_peak)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  got [NO];
    logic        got_last [NO];
    int          got_n;
    int          run_cyc;
    bit          done_seen;
    logic [17:0] done_peak;

    typedef struct {
        logic [7:0]  mag;
        logic [7:0]  wgt;
        logic [2:0]  bin;
        bit          gaps;
        bit          stall;
        bit          spur;
        logic [7:0]  exp_hit;
        logic [17:0] exp_peak;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_desc(input logic [7:0] mag, input logic [7:0] wgt, input logic [2:0] bin,
                           input bit gaps, input bit stall, input bit spur);
        int         sent;
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        sent = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        got_n = 0;
        done_seen = 1'b0;
        run_cyc = 0;
        done_peak = '0;
        if (spur) begin
            in_valid = 1'b1;
            in_mag = 8'd255;
            in_wgt = 8'd255;
            in_bin = bin;
            repeat (3) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_single_pulse", done, 0);
        cyc = 1;
        while (!done_seen && cyc < 4000) begin
            start = spur && (cyc == 50 || (out_valid && got_n == 20));
            in_valid = (sent < NS) ? (!gaps || ($urandom_range(0, 2) != 0)) : spur;
            in_mag = mag;
            in_wgt = wgt;
            in_bin = bin;
            out_ready = !stall || ($urandom_range(0, 1) == 1);
            if (out_valid) begin
                if (prev_stall) begin
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", out_last, prev_last);
                end
                if (out_ready && got_n < NO) begin
                    got[got_n] = out_data;
                    got_last[got_n] = out_last;
                    got_n++;
                end
                prev_stall = !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end else begin
                prev_stall = 1'b0;
            end
            if (in_valid && sent < NS) sent++;
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                done_seen = 1'b1;
                run_cyc = cyc;
                done_peak = peak;
                chk("done_out_valid", out_valid, 0);
                chk("done_busy", busy, 0);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (!done_seen) chk("done_timeout", 0, 1);
    endtask

    task automatic check_run(input logic [2:0] bin, input logic [7:0] hit, input logic [17:0] exp_peak,
                             input bit check_lat);
        logic [7:0] e;
        chk("elem_count", got_n, NO);
        for (int k = 0; k < got_n; k++) begin
            e = ((k % 8) == int'(bin)) ? hit : 8'd0;
            chk($sformatf("elem%0d", k), got[k], e);
            chk($sformatf("last%0d", k), got_last[k], (k == NO - 1) ? 1 : 0);
        end
        chk("peak", done_peak, exp_peak);
        if (check_lat) chk("latency", run_cyc, 1 + NS + 1 + NO);
    endtask

    initial begin
        int sg;
        int cyc;

        // acc per hit bin = 16*mag*wgt (saturated at 262143); element = min(acc>>2, 255)
        vecs[0] = '{8'd1,   8'd1,   3'd0, 1'b0, 1'b0, 1'b0, 8'd4,   18'd16};
        vecs[1] = '{8'd255, 8'd255, 3'd3, 1'b0, 1'b0, 1'b0, 8'd255, 18'd262143};
        vecs[2] = '{8'd3,   8'd5,   3'd7, 1'b1, 1'b1, 1'b0, 8'd60,  18'd240};
        vecs[3] = '{8'd20,  8'd50,  3'd5, 1'b0, 1'b0, 1'b0, 8'd255, 18'd16000};
        vecs[4] = '{8'd1,   8'd1,   3'd0, 1'b1, 1'b1, 1'b1, 8'd4,   18'd16};
        vecs[5] = '{8'd2,   8'd3,   3'd6, 1'b0, 1'b0, 1'b1, 8'd24,  18'd96};

        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_peak", peak, 0);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_s_out_valid", s_out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // consecutive calls start in the done cycle, exercising back-to-back operation
        for (int v = 0; v < 6; v++) begin
            do_desc(vecs[v].mag, vecs[v].wgt, vecs[v].bin, vecs[v].gaps, vecs[v].stall, vecs[v].spur);
            check_run(vecs[v].bin, vecs[v].exp_hit, vecs[v].exp_peak, !vecs[v].gaps && !vecs[v].stall);
        end

        // abort after 100 samples; large values would leave visible residue
        repeat (2) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_mag = 8'd200;
        in_wgt = 8'd200;
        in_bin = 3'd5;
        repeat (100) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_peak", peak, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #1;
        do_desc(8'd1, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0);
        check_run(3'd0, 8'd4, 18'd16, 1'b1);

        // 2x2x4 config: each 4x4 sub holds 4 samples per bin, acc = 4*2 = 8, element = 8>>2 = 2
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int n = 0; n < 64; n++) begin
            s_in_valid = 1'b1;
            s_in_bin = 2'(n % 4);
            s_in_mag = 8'd2;
            s_in_wgt = 8'd1;
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        sg = 0;
        cyc = 0;
        while (sg < 16 && cyc < 200) begin
            if (s_out_valid) begin
                chk($sformatf("s_elem%0d", sg), s_out_data, 2);
                chk($sformatf("s_last%0d", sg), s_out_last, (sg == 15) ? 1 : 0);
                sg++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("s_elem_count", sg, 16);
        chk("s_done", s_done, 1);
        chk("s_peak", s_peak, 8);
        chk("s_out_valid_after", s_out_valid, 0);
        s_out_ready = 1'b0;
        @(posedge clk); #1;
        chk("s_done_pulse", s_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
